// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB arbiter slice.
package cdb_pkg;

  localparam int unsigned PHY_REG_W_DEF = 7;
  localparam int unsigned VAL_W_DEF     = 32;
  localparam int unsigned TAG_W_DEF     = 6;

  // One buffered FU result / one CDB broadcast payload.
  typedef struct packed {
    logic [PHY_REG_W_DEF-1:0] phy_reg;
    logic [VAL_W_DEF-1:0]     val;
    logic [TAG_W_DEF-1:0]     tag;
    logic                     reg_wb;
  } cdb_entry_t;

  localparam cdb_entry_t CDB_NOP_ENTRY = '0;

  // Index width that stays at least one bit when there is a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result and CDB broadcast signals between the execute stage and the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PHY_REG_W = cdb_pkg::PHY_REG_W_DEF,
  parameter int unsigned VAL_W     = cdb_pkg::VAL_W_DEF,
  parameter int unsigned TAG_W     = cdb_pkg::TAG_W_DEF
);
  localparam int unsigned IDX_W = cdb_pkg::idx_w(NUM_REQ);

  logic                           flush;
  logic [NUM_REQ-1:0]             fu_valid;
  logic [NUM_REQ-1:0]             fu_ready;
  logic [NUM_REQ*PHY_REG_W-1:0]   fu_phy_reg;
  logic [NUM_REQ*VAL_W-1:0]       fu_val;
  logic [NUM_REQ*TAG_W-1:0]       fu_tag;
  logic [NUM_REQ-1:0]             fu_reg_wb;
  logic                           cdb_valid;
  logic [PHY_REG_W-1:0]           cdb_register_addr;
  logic [VAL_W-1:0]               cdb_register_val;
  logic [TAG_W-1:0]               cdb_inst_tag;
  logic                           cdb_reg_wb;
  logic [IDX_W-1:0]               grant_id;

  // Execute-stage / pipeline-control side.
  modport master (
    output flush, fu_valid, fu_phy_reg, fu_val, fu_tag, fu_reg_wb,
    input  fu_ready, cdb_valid, cdb_register_addr, cdb_register_val,
           cdb_inst_tag, cdb_reg_wb, grant_id
  );

  // Arbiter side.
  modport slave (
    input  flush, fu_valid, fu_phy_reg, fu_val, fu_tag, fu_reg_wb,
    output fu_ready, cdb_valid, cdb_register_addr, cdb_register_val,
           cdb_inst_tag, cdb_reg_wb, grant_id
  );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or above rr_ptr, wrapping.
module rr_arbiter
  import cdb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          found;
  int unsigned   idx;

  // Search from rr_ptr upward; grant only when allowed to advance.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    rr_ptr_d  = rr_ptr_q;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(rr_ptr_q) + off) % N;
      if (!found && req[IW'(idx)]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found && advance) begin
      grant[grant_idx] = 1'b1;
      rr_ptr_d         = IW'((32'(grant_idx) + 1) % N);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-FU one-entry holding buffers, round-robin grant, registered CDB broadcast.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PHY_REG_W = PHY_REG_W_DEF,
  parameter int unsigned VAL_W     = VAL_W_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  cdb_entry_t         buf_q [NUM_REQ];
  cdb_entry_t         buf_d [NUM_REQ];
  logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] capture;
  logic [IW-1:0]      grant_idx;

  cdb_entry_t         cdb_q, cdb_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (buf_valid_q),
    .advance   (~bus.flush),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A buffer accepts when empty or being drained this cycle; never during flush.
  assign bus.fu_ready = ~{NUM_REQ{bus.flush}} & (~buf_valid_q | grant);
  assign capture      = bus.fu_valid & bus.fu_ready;

  // Holding-buffer next state: flush clears, capture refills, grant drains.
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (bus.flush) begin
        buf_valid_d[i] = 1'b0;
      end else if (capture[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_d[i] = '{phy_reg: PHY_REG_W_DEF'(bus.fu_phy_reg[i*PHY_REG_W +: PHY_REG_W]),
                     val:     VAL_W_DEF'(bus.fu_val[i*VAL_W +: VAL_W]),
                     tag:     TAG_W_DEF'(bus.fu_tag[i*TAG_W +: TAG_W]),
                     reg_wb:  bus.fu_reg_wb[i]};
      end else if (grant[i]) begin
        buf_valid_d[i] = 1'b0;
      end
    end
  end

  // Broadcast register: load the granted entry, otherwise hold data and drop valid.
  always_comb begin
    cdb_valid_d = |grant;
    cdb_d       = cdb_q;
    grant_id_d  = grant_id_q;
    if (|grant) begin
      cdb_d      = buf_q[grant_idx];
      grant_id_d = grant_idx;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REQ); i++) buf_q[i] <= CDB_NOP_ENTRY;
      buf_valid_q <= '0;
      cdb_q       <= CDB_NOP_ENTRY;
      cdb_valid_q <= 1'b0;
      grant_id_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) buf_q[i] <= buf_d[i];
      buf_valid_q <= buf_valid_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign bus.cdb_valid         = cdb_valid_q;
  assign bus.cdb_register_addr = PHY_REG_W'(cdb_q.phy_reg);
  assign bus.cdb_register_val  = VAL_W'(cdb_q.val);
  assign bus.cdb_inst_tag      = TAG_W'(cdb_q.tag);
  assign bus.cdb_reg_wb        = cdb_q.reg_wb;
  assign bus.grant_id          = grant_id_q;

endmodule
